// File: rtl/spi_alu_responder_if.sv
// rtl/spi_alu_responder_if.sv - SPI link bundle shared by the master and the ALU responder
interface IF_SPI;
  logic nss;
  logic mosi;
  logic miso;

  modport SLAVE  (input nss, input mosi, output miso);
  modport MASTER (output nss, output mosi, input miso);
endinterface

// File: rtl/spi_alu_responder.sv
// rtl/spi_alu_responder.sv - SPI-side ALU responder: 66-bit command in, 32-bit result out
// SPI_ALU_MUL_EN: opcode 11 computes low 32 bits of A*B instead of A|B.
module spi_alu_responder (
  input  logic        clock,
  input  logic        reset,
  IF_SPI.SLAVE        spi,
  output logic        result_valid,
  output logic [31:0] result,
  output logic        frame_err,
  output logic        busy
);
  typedef enum logic [2:0] {IDLE, RECV, CALC, READY, RESP} state_t;

  state_t      state, state_next;
  logic        nss_d;
  logic [65:0] rx_shift;
  logic [6:0]  rx_cnt;
  logic [31:0] tx_shift;
  logic [5:0]  tx_cnt;
  logic        armed;
  logic        err_next;
  logic [1:0]  opcode;
  logic [31:0] op_a, op_b, alu;

  assign opcode = rx_shift[65:64];
  assign op_a   = rx_shift[63:32];
  assign op_b   = rx_shift[31:0];
  assign busy   = (state != IDLE);
  assign spi.miso = (state == READY || state == RESP) ? tx_shift[31] : 1'b0;

  always_comb begin
    alu = '0;
    case (opcode)
      2'b00:   alu = op_a + op_b;
      2'b01:   alu = op_a - op_b;
      2'b10:   alu = op_a & op_b;
      default:
`ifdef SPI_ALU_MUL_EN
        alu = op_a * op_b;
`else
        alu = op_a | op_b;
`endif
    endcase
  end

  always_comb begin
    state_next = state;
    err_next   = 1'b0;
    case (state)
      IDLE:  if (!nss_d) state_next = RECV;
      RECV: begin
        if (nss_d) begin
          state_next = IDLE;
          err_next   = 1'b1;
        end else if (rx_cnt == 7'd65) begin
          state_next = CALC;
        end
      end
      CALC:  state_next = READY;
      // The response window only opens after NSS has been seen high in READY.
      READY: if (armed && !nss_d) state_next = RESP;
      RESP: begin
        if (nss_d) begin
          state_next = IDLE;
          err_next   = 1'b1;
        end else if (tx_cnt == 6'd31) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state        <= IDLE;
      nss_d        <= 1'b1;
      rx_shift     <= '0;
      rx_cnt       <= '0;
      tx_shift     <= '0;
      tx_cnt       <= '0;
      armed        <= 1'b0;
      result       <= '0;
      result_valid <= 1'b0;
      frame_err    <= 1'b0;
    end else begin
      state        <= state_next;
      nss_d        <= spi.nss;
      frame_err    <= err_next;
      result_valid <= (state == CALC);
      case (state)
        IDLE: begin
          if (!nss_d) begin
            rx_shift <= {rx_shift[64:0], spi.mosi};
            rx_cnt   <= 7'd1;
          end
        end
        RECV: begin
          if (nss_d) begin
            rx_cnt <= '0;
          end else begin
            rx_shift <= {rx_shift[64:0], spi.mosi};
            rx_cnt   <= (rx_cnt == 7'd65) ? 7'd0 : rx_cnt + 7'd1;
          end
        end
        CALC: begin
          result   <= alu;
          tx_shift <= alu;
          armed    <= 1'b0;
        end
        READY: begin
          if (nss_d) begin
            armed <= 1'b1;
          end else if (armed) begin
            tx_shift <= {tx_shift[30:0], 1'b0};
            tx_cnt   <= 6'd1;
          end
        end
        RESP: begin
          if (nss_d || tx_cnt == 6'd31) begin
            tx_cnt <= '0;
          end else begin
            tx_shift <= {tx_shift[30:0], 1'b0};
            tx_cnt   <= tx_cnt + 6'd1;
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_spi_alu_responder.sv
// tb/tb_spi_alu_responder.sv - directed bench for spi_alu_responder
module tb_spi_alu_responder;
  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        result_valid;
  logic [31:0] result;
  logic        frame_err;
  logic        busy;
  int          total = 0;
  int          bad = 0;
  logic [31:0] last_exp = 32'h0;

  IF_SPI spi ();

  spi_alu_responder dut (
    .clock        (clock),
    .reset        (reset),
    .spi          (spi),
    .result_valid (result_valid),
    .result       (result),
    .frame_err    (frame_err),
    .busy         (busy)
  );

  always #5 clock = ~clock;

  task automatic run_cmd(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] exp, input string name);
    logic [65:0] frame;
    frame = {op, a, b};
    spi.nss = 1'b0;
    spi.mosi = 1'b0;
    for (int i = 65; i >= 0; i--) begin
      @(negedge clock);
      spi.mosi = frame[i];
    end
    @(negedge clock);
    spi.nss = 1'b1;
    spi.mosi = 1'b0;
    @(negedge clock);
    total++;
    if (result_valid !== 1'b1 || result !== exp) begin
      bad++;
      $display("FAIL %s_result: valid=%0b result=%h, required valid=1 result=%h", name, result_valid, result, exp);
    end
    total++;
    if (spi.miso !== exp[31]) begin
      bad++;
      $display("FAIL %s_first_miso: got %0b, required %0b", name, spi.miso, exp[31]);
    end
    @(negedge clock);
    total++;
    if (result_valid !== 1'b0 || frame_err !== 1'b0) begin
      bad++;
      $display("FAIL %s_pulse: valid=%0b frame_err=%0b, required 0 0", name, result_valid, frame_err);
    end
    last_exp = exp;
  endtask

  task automatic read_resp(input logic [31:0] exp, input string name);
    logic [31:0] got;
    got = '0;
    spi.nss = 1'b0;
    for (int k = 0; k < 32; k++) begin
      @(negedge clock);
      got[31-k] = spi.miso;
    end
    spi.nss = 1'b1;
    @(negedge clock);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s_miso: got %h, required %h", name, got, exp);
    end
    total++;
    if (busy !== 1'b0 || spi.miso !== 1'b0 || frame_err !== 1'b0) begin
      bad++;
      $display("FAIL %s_idle: busy=%0b miso=%0b frame_err=%0b, required 0 0 0", name, busy, spi.miso, frame_err);
    end
    @(negedge clock);
  endtask

  task automatic test_reset;
    total++;
    if (result !== 32'h0 || result_valid !== 1'b0 || frame_err !== 1'b0 || busy !== 1'b0 || spi.miso !== 1'b0) begin
      bad++;
      $display("FAIL reset: result=%h valid=%0b ferr=%0b busy=%0b miso=%0b, required all 0",
               result, result_valid, frame_err, busy, spi.miso);
    end
  endtask

  task automatic test_alu_ops;
    run_cmd(2'b00, 32'h0000_0005, 32'h0000_0007, 32'h0000_000C, "add");
    read_resp(32'h0000_000C, "add");
    run_cmd(2'b00, 32'hFFFF_FFFF, 32'h0000_0002, 32'h0000_0001, "add_wrap");
    read_resp(32'h0000_0001, "add_wrap");
    run_cmd(2'b01, 32'h0000_0003, 32'h0000_0005, 32'hFFFF_FFFE, "sub");
    read_resp(32'hFFFF_FFFE, "sub");
    run_cmd(2'b10, 32'hF0F0_FFFF, 32'h0FF0_F00F, 32'h00F0_F00F, "and");
    read_resp(32'h00F0_F00F, "and");
`ifdef SPI_ALU_MUL_EN
    run_cmd(2'b11, 32'h0001_0003, 32'h0000_0004, 32'h0004_000C, "op11");
    read_resp(32'h0004_000C, "op11");
`else
    run_cmd(2'b11, 32'h0001_0003, 32'h0000_0004, 32'h0001_0007, "op11");
    read_resp(32'h0001_0007, "op11");
`endif
  endtask

  task automatic test_abort_cmd;
    logic [65:0] frame;
    int fe, rv;
    logic fe_busy;
    frame = {2'b00, 32'hAAAA_5555, 32'h1234_5678};
    fe = 0;
    rv = 0;
    fe_busy = 1'b1;
    spi.nss = 1'b0;
    spi.mosi = 1'b0;
    for (int i = 65; i >= 26; i--) begin
      @(negedge clock);
      spi.mosi = frame[i];
    end
    @(negedge clock);
    spi.nss = 1'b1;
    spi.mosi = 1'b0;
    for (int j = 0; j < 4; j++) begin
      @(negedge clock);
      if (frame_err === 1'b1) begin
        fe++;
        fe_busy = busy;
      end
      if (result_valid === 1'b1) rv++;
    end
    total++;
    if (fe != 1 || fe_busy !== 1'b0) begin
      bad++;
      $display("FAIL abort_cmd_err: pulses=%0d busy=%0b, required 1 0", fe, fe_busy);
    end
    total++;
    if (rv != 0 || result !== last_exp) begin
      bad++;
      $display("FAIL abort_cmd_result: valid_pulses=%0d result=%h, required 0 %h", rv, result, last_exp);
    end
    run_cmd(2'b00, 32'h0000_0100, 32'h0000_0001, 32'h0000_0101, "after_abort");
    read_resp(32'h0000_0101, "after_abort");
  endtask

  task automatic test_short_resp;
    logic [31:0] got;
    int fe;
    got = '0;
    fe = 0;
    run_cmd(2'b00, 32'h1234_5678, 32'h1111_1111, 32'h2345_6789, "short");
    spi.nss = 1'b0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clock);
      got[31-k] = spi.miso;
    end
    spi.nss = 1'b1;
    for (int j = 0; j < 4; j++) begin
      @(negedge clock);
      if (frame_err === 1'b1) fe++;
    end
    total++;
    if (got[31:22] !== 10'b0010_0011_01) begin
      bad++;
      $display("FAIL short_bits: got %b, required 0010001101", got[31:22]);
    end
    total++;
    if (fe != 1 || busy !== 1'b0) begin
      bad++;
      $display("FAIL short_err: pulses=%0d busy=%0b, required 1 0", fe, busy);
    end
    run_cmd(2'b01, 32'h0000_0010, 32'h0000_0001, 32'h0000_000F, "after_short");
    read_resp(32'h0000_000F, "after_short");
  endtask

  task automatic test_reset_mid_recv;
    logic [65:0] frame;
    frame = {2'b10, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
    spi.nss = 1'b0;
    for (int i = 65; i >= 36; i--) begin
      @(negedge clock);
      spi.mosi = frame[i];
    end
    reset = 1'b0;
    spi.nss = 1'b1;
    spi.mosi = 1'b0;
    @(negedge clock);
    test_reset();
    reset = 1'b1;
    last_exp = 32'h0;
    @(negedge clock);
    total++;
    if (busy !== 1'b0 || result !== 32'h0) begin
      bad++;
      $display("FAIL reset_release: busy=%0b result=%h, required 0 00000000", busy, result);
    end
  endtask

  task automatic test_extra_bits;
    logic [65:0] frame;
    int rv;
    frame = {2'b00, 32'h0000_0100, 32'h0000_0023};
    rv = 0;
    spi.nss = 1'b0;
    for (int i = 65; i >= 0; i--) begin
      @(negedge clock);
      spi.mosi = frame[i];
    end
    for (int j = 0; j < 8; j++) begin
      @(negedge clock);
      spi.mosi = 1'b1;
      if (result_valid === 1'b1) rv++;
    end
    spi.nss = 1'b1;
    spi.mosi = 1'b0;
    total++;
    if (rv != 1 || result !== 32'h0000_0123 || busy !== 1'b1) begin
      bad++;
      $display("FAIL extra_bits: pulses=%0d result=%h busy=%0b, required 1 00000123 1", rv, result, busy);
    end
    @(negedge clock);
    read_resp(32'h0000_0123, "extra_bits");
  endtask

  initial begin
    spi.nss = 1'b1;
    spi.mosi = 1'b0;
    reset = 1'b0;
    repeat (2) @(negedge clock);
    test_reset();
    reset = 1'b1;
    @(negedge clock);
    test_alu_ops();
    test_abort_cmd();
    test_short_resp();
    test_reset_mid_recv();
    test_extra_bits();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
